// File: rtl/apb_pkg.sv
// Shared definitions for the APB pin-level master: FSM encoding, PPROT bit
// constants and the byte-strobe width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // pprot[0]=privileged, pprot[1]=non-secure, pprot[2]=instruction
    localparam logic [2:0] PPROT_NORMAL     = 3'b000;
    localparam logic [2:0] PPROT_PRIVILEGED = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE  = 3'b010;
    localparam logic [2:0] PPROT_INSTR      = 3'b100;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_pin_master_if.sv
// Pin-level command/response channel plus APB bus of the pin master.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
interface apb_pin_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                                        cmd_valid;
    logic                                        cmd_ready;
    logic [ADDR_WIDTH-1:0]                       cmd_addr;
    logic                                        cmd_write;
    logic [DATA_WIDTH-1:0]                       cmd_wdata;
    logic                                        rsp_valid;
    logic [DATA_WIDTH-1:0]                       rsp_rdata;
    logic                                        rsp_error;
    logic                                        rsp_timeout;
    logic [ADDR_WIDTH-1:0]                       paddr;
    logic [2:0]                                  pprot;
    logic                                        psel;
    logic                                        penable;
    logic                                        pwrite;
    logic [DATA_WIDTH-1:0]                       pwdata;
    logic [apb_pkg::strb_width(DATA_WIDTH)-1:0]  pstrb;
    logic                                        pready;
    logic [DATA_WIDTH-1:0]                       prdata;
    logic                                        pslverr;
    apb_pkg::state_t                             dbg_state;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
               paddr, pprot, psel, penable, pwrite, pwdata, pstrb, dbg_state
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
               paddr, pprot, psel, penable, pwrite, pwdata, pstrb, dbg_state
    );

endinterface

// File: rtl/apb_pin_master.sv
// Runs single-beat pin commands as APB SETUP/ACCESS transfers and returns a
// one-cycle response pulse; an ACCESS-phase timeout guards against a dead slave.
module apb_pin_master #(
    parameter int         ADDR_WIDTH     = 4,
    parameter int         DATA_WIDTH     = 8,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [2:0] PPROT_VALUE    = 3'b000
) (
    input  logic              pclk,
    input  logic              preset,
    apb_pin_master_if.master  bus
);
    import apb_pkg::*;

    localparam int STRB_W  = strb_width(DATA_WIDTH);
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;

    logic w_accept;
    logic w_done;
    logic w_timeout;
    logic w_cmd_ready;
    logic w_psel;
    logic w_penable;

    assign w_accept  = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_done    = (r_state == ST_ACCESS) && bus.pready;
    // pready wins over the timeout on the last allowed ACCESS cycle
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ST_ACCESS) &&
                       !bus.pready && (r_cnt == CNT_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_done || w_timeout) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        case (r_state)
            ST_IDLE:   w_cmd_ready = 1'b1;
            ST_SETUP:  w_psel      = 1'b1;
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            default:   w_cmd_ready = 1'b0;
        endcase
    end

    // Bus fields are loaded only at accept, so they hold through ACCESS and stay put in IDLE.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt         <= '0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_cnt    <= '0;
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
                r_pstrb  <= bus.cmd_write ? '1 : '0;
            end
            if (w_done) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                r_rsp_error   <= bus.pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= '0;
                r_rsp_error   <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end else if (r_state == ST_ACCESS) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.psel        = w_psel;
    assign bus.penable     = w_penable;
    assign bus.paddr       = r_paddr;
    assign bus.pwrite      = r_pwrite;
    assign bus.pwdata      = r_pwdata;
    assign bus.pstrb       = r_pstrb;
    assign bus.pprot       = PPROT_VALUE;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_apb_pin_master.sv
// Directed bench for apb_pin_master: table of whole transactions plus
// hand-written back-to-back and mid-transfer reset sequences.
module tb_apb_pin_master;
    import apb_pkg::*;

    localparam int         AW     = 4;
    localparam int         DW     = 8;
    localparam int         SW     = DW / 8;
    localparam int         TO     = 4;
    localparam logic [2:0] PPROT  = 3'b010;
    localparam int         NVEC   = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        int            waits;      // ACCESS cycles with pready=0; -1 = never ready
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_lat;    // cycle of rsp_valid, accept edge = cycle 0
        int            exp_acc;    // cycles with penable high
    } vec_t;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [AW-1:0] exp_q[$];
    vec_t vecs[NVEC];

    always #5 pclk = ~pclk;

    apb_pin_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    apb_pin_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .PPROT_VALUE(PPROT)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
    endtask

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input string tag, input vec_t v);
        int            acc;
        int            rsp_c;
        logic          got;
        logic [SW-1:0] exp_strb;
        exp_strb = v.write ? '1 : '0;
        acc = 0;
        rsp_c = 0;
        got = 1'b0;
        chk({tag, "_ready_idle"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = v.addr;
        bus.cmd_write = v.write;
        bus.cmd_wdata = v.wdata;
        step();
        // scrambled command pins must not leak into the running transfer
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_write = ~v.write;
        bus.cmd_wdata = ~v.wdata;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (bus.rsp_valid) begin
                got = 1'b1;
                rsp_c = c;
            end else begin
                if (c == 1) begin
                    chk({tag, "_setup_psel"}, bus.psel, 1);
                    chk({tag, "_setup_penable"}, bus.penable, 0);
                    chk({tag, "_setup_state"}, bus.dbg_state, ST_SETUP);
                    chk({tag, "_setup_ready"}, bus.cmd_ready, 0);
                end
                if (bus.psel) begin
                    chk({tag, "_paddr"}, bus.paddr, v.addr);
                    chk({tag, "_pwrite"}, bus.pwrite, v.write);
                    chk({tag, "_pwdata"}, bus.pwdata, v.wdata);
                    chk({tag, "_pstrb"}, bus.pstrb, exp_strb);
                    chk({tag, "_pprot"}, bus.pprot, PPROT);
                end
                if (bus.penable) acc++;
            end
            bus.pready  = !got && bus.penable && (v.waits >= 0) && (acc == v.waits + 1);
            bus.prdata  = bus.pready ? v.prdata : 8'hEE;
            bus.pslverr = bus.pready ? v.slverr : 1'b1;
            if (!got) step();
        end
        chk({tag, "_rsp_seen"}, got, 1);
        chk({tag, "_latency"}, rsp_c, v.exp_lat);
        chk({tag, "_access_cycles"}, acc, v.exp_acc);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_error"}, bus.rsp_error, v.exp_err);
        chk({tag, "_rsp_timeout"}, bus.rsp_timeout, v.exp_to);
        chk({tag, "_rsp_psel"}, bus.psel, 0);
        chk({tag, "_rsp_ready"}, bus.cmd_ready, 1);
        idle_inputs();
        step();
        chk({tag, "_rsp_one_cycle"}, bus.rsp_valid, 0);
        chk({tag, "_rdata_held"}, bus.rsp_rdata, v.exp_rdata);
        chk({tag, "_paddr_held"}, bus.paddr, v.addr);
    endtask

    task automatic back_to_back();
        int            n_acc;
        int            acc_cyc[$];
        int            rsp_cyc[$];
        logic [AW-1:0] seen_addr;
        logic [AW-1:0] exp_addr;
        n_acc = 0;
        seen_addr = '0;
        bus.pready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (bus.rsp_valid) begin
                rsp_cyc.push_back(c);
                chk("b2b_rsp_error", bus.rsp_error, 0);
                chk("b2b_rsp_rdata", bus.rsp_rdata, 0);
                chk("b2b_q_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_addr = exp_q.pop_front();
                    chk("b2b_paddr", seen_addr, exp_addr);
                end
            end
            if (c >= 1 && c <= 9) chk("b2b_psel", bus.psel, (c % 3) != 0);
            if (bus.psel && !bus.penable) seen_addr = bus.paddr;
            if (bus.cmd_ready) begin
                if (n_acc < 3) begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_addr  = AW'(n_acc);
                    bus.cmd_write = 1'b1;
                    bus.cmd_wdata = DW'(8'h10 + n_acc);
                    acc_cyc.push_back(c);
                    exp_q.push_back(AW'(n_acc));
                    n_acc++;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            step();
        end
        idle_inputs();
        chk("b2b_accepts", acc_cyc.size(), 3);
        chk("b2b_responses", rsp_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < acc_cyc.size()) chk("b2b_accept_cycle", acc_cyc[i], 3 * i);
            if (i < rsp_cyc.size()) chk("b2b_rsp_cycle", rsp_cyc[i], 3 * i + 3);
        end
    endtask

    task automatic reset_mid_transfer();
        vec_t v;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 4'h5;
        bus.cmd_write = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("rst_mid_in_access", bus.penable, 1);
        preset = 1'b1;
        step();
        chk("rst_mid_psel", bus.psel, 0);
        chk("rst_mid_penable", bus.penable, 0);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mid_ready", bus.cmd_ready, 1);
        chk("rst_mid_state", bus.dbg_state, ST_IDLE);
        preset = 1'b0;
        step();
        chk("rst_mid_no_rsp", bus.rsp_valid, 0);
        v = '{addr: 4'h6, write: 1'b1, wdata: 8'h77, waits: 0, prdata: 8'h00, slverr: 1'b0,
              exp_rdata: 8'h00, exp_err: 1'b0, exp_to: 1'b0, exp_lat: 3, exp_acc: 1};
        run_txn("after_rst", v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr   wr    wdata  waits prdata slverr exp_rd exp_err exp_to lat acc
        vecs[0] = '{4'h3, 1'b1, 8'hA5,  0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3, 1};
        vecs[1] = '{4'h3, 1'b0, 8'h00,  2, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 5, 3};
        vecs[2] = '{4'hF, 1'b0, 8'h00,  0, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 3, 1};
        vecs[3] = '{4'h7, 1'b0, 8'h00, -1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 6, 4};
        vecs[4] = '{4'h7, 1'b0, 8'h00,  3, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 6, 4};
        vecs[5] = '{4'h9, 1'b1, 8'h3C,  1, 8'h99, 1'b1, 8'h00, 1'b1, 1'b0, 4, 2};
        vecs[6] = '{4'h2, 1'b1, 8'hC3, -1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 6, 4};
        vecs[7] = '{4'h8, 1'b0, 8'h00,  0, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 3, 1};

        idle_inputs();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_error", bus.rsp_error, 0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_pstrb", bus.pstrb, 0);
        chk("rst_pprot", bus.pprot, PPROT);
        chk("rst_state", bus.dbg_state, ST_IDLE);

        for (int i = 0; i < NVEC; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        back_to_back();
        reset_mid_transfer();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_pin_master.md
Name: apb_pin_master

Overview:
- Upstream APB requester that drives the APB slave register file.
- Takes single-beat commands from a pin-level valid/ready interface (address, direction, write data).
- Runs each command as a compliant APB SETUP/ACCESS transfer and returns read data and error status as a one-cycle response pulse.
- Includes an ACCESS-phase timeout, so a slave that never asserts pready cannot hang the pin interface.

Parameters:
- ADDR_WIDTH, 4, width of cmd_addr and paddr
- DATA_WIDTH, 8, width of data buses; must be a multiple of 8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout
- PPROT_VALUE, 3'b000, constant driven on pprot

Ports:
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_error  out  1  pslverr seen, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_WIDTH  APB address
- pprot  out  3  APB protection (PPROT_VALUE)
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  all ones on writes, all zeros on reads
- pready  in  1  APB ready
- prdata  in  DATA_WIDTH  APB read data
- pslverr  in  1  APB slave error

Behaviour:
- Clock and reset: one clock domain (pclk). preset is synchronous, active-high.
- Reset: state IDLE; cmd_ready=1; all other outputs 0 except pprot=PPROT_VALUE; timeout counter 0.
- Reset mid-transfer: psel and penable drop at that edge; no response is issued.
- States:
  - IDLE: cmd_ready=1, psel=0, penable=0. On accept, register addr/write/wdata/strb onto the APB outputs; go to SETUP.
  - SETUP: psel=1, penable=0, cmd_ready=0; pready ignored. Always go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. Counter increments each cycle pready=0.
    - If pready=1: capture prdata (reads) and pslverr; go to IDLE.
    - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: abort to IDLE with rsp_error=1, rsp_timeout=1.
    - pready has priority if it arrives on the final allowed cycle.
- Response: rsp_valid=1 for exactly the first IDLE cycle after a completed or aborted transfer. rsp_rdata, rsp_error and rsp_timeout stay valid until the next rsp_valid. No back-pressure; the consumer must sample on the pulse.
- Stability: paddr, pwrite, pwdata, pstrb constant from SETUP through the end of ACCESS. They keep their last values while IDLE. Counter clears on entry to SETUP.
- Write responses: rsp_rdata=0. pslverr is sampled only when pready=1.
- Latency: accept edge at cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2 → rsp_valid in cycle 3 with a zero-wait slave. Each pready wait state adds 1 cycle.
- Throughput: cmd_ready is high during the rsp_valid cycle, so back-to-back commands complete one per 3 cycles.
- cmd_valid while busy: held off; cmd_* inputs are not sampled outside IDLE.

Decomposition:
- Shared package apb_pkg:
  - state encoding IDLE/SETUP/ACCESS (2 bits)
  - PPROT constants (normal/privileged/secure/instruction bits)
  - helper constant for strobe width = DATA_WIDTH/8
- No sub-module needed. The timeout counter is inline, width clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Reset, then write: cmd addr=4'h3, wdata=8'hA5, write=1; slave pready=1 immediately → psel cycle 1, penable cycle 2, pwdata=A5, pstrb=1; rsp_valid cycle 3, rsp_error=0, rsp_rdata=0.
- Read back addr=4'h3 with slave returning 8'hA5 and 2 wait states → penable held 3 cycles with paddr stable; rsp_valid cycle 5, rsp_rdata=A5, pstrb=0 during the transfer.
- Slave error: read addr=4'hF, slave pready=1, pslverr=1 → rsp_error=1, rsp_timeout=0.
- Timeout, TIMEOUT_CYCLES=4, pready tied 0 → penable high exactly 4 cycles, then psel=0; rsp_valid with rsp_error=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on the 4th ACCESS cycle → normal completion, rsp_timeout=0.
- Back-to-back: cmd_valid held high for 3 writes (addr 0,1,2) → accepts at cycles 0, 3, 6; three rsp_valid pulses at cycles 3, 6, 9; psel never low between transfers except in the IDLE cycle.
- Assert preset during ACCESS → psel and penable 0 at the next edge, no rsp_valid; cmd_ready=1; the next command completes normally.
